bp_dma_responder: RTL and testbench

BP_DMA_RESPONDER -- requirements
Module: bp_dma_responder

---
 rtl/bsg_cache_pkg.sv | 23 ++
 rtl/bsg_mem_1rw_sync.sv | 32 +++
 rtl/bp_dma_responder.sv | 134 +++++++++++++
 tb/tb_bp_dma_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared cache/DMA definitions.
//   DECLARE_BSG_CACHE_DMA_PKT_S(addr_width) : declares the packed DMA packet
//     struct {write_not_read, addr[addr_width]} inside the calling module.
//   bsg_cache_pkg::safe_clog2               : clog2 that never returns 0, so
//     index widths stay legal for degenerate sizes.
`ifndef BSG_CACHE_PKG_SV
`define BSG_CACHE_PKG_SV

`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) \
  typedef struct packed { \
    logic                     write_not_read; \
    logic [addr_width_mp-1:0] addr; \
  } bsg_cache_dma_pkt_s

package bsg_cache_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

`endif

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM, one access per cycle.
//   clk_i  : clock
//   v_i    : access enable
//   w_i    : 1 = write data_i, 0 = read into data_o
//   addr_i : word address
//   data_i : write data
//   data_o : read data, registered; holds its value on cycles with no read
// Contents are not reset.
module bsg_mem_1rw_sync
  import bsg_cache_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 1024
) (
  input  logic                          clk_i,
  input  logic                          v_i,
  input  logic                          w_i,
  input  logic [safe_clog2(els_p)-1:0]  addr_i,
  input  logic [width_p-1:0]            data_i,
  output logic [width_p-1:0]            data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) mem[addr_i] <= data_i;
      else     data_o      <= mem[addr_i];
    end
  end

endmodule

// File: rtl/bp_dma_responder.sv
// DMA responder backed by a single-port RAM, modelling main memory for a
// cache's DMA port.
//   clk_i, reset_i                 : clock, async active-high reset
//   dma_pkt_i/_v_i/_yumi_o         : request packet {write_not_read, addr}
//   dma_data_o/_v_o/_ready_and_i   : read-data beats towards the cache
//   dma_data_i/_v_i/_yumi_o        : writeback beats from the cache
// Each transfer moves block_size_in_fills_p beats starting at the beat index
// of addr, wrapping modulo mem_els_p.
module bp_dma_responder
  import bsg_cache_pkg::*;
#(
  parameter int caddr_width_p         = 28,
  parameter int fill_width_p          = 64,
  parameter int block_size_in_fills_p = 8,
  parameter int mem_els_p             = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [caddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,

  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,

  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o
);

  `DECLARE_BSG_CACHE_DMA_PKT_S(caddr_width_p);

  localparam int lg_els_lp = safe_clog2(mem_els_p);
  localparam int offset_lp = $clog2(fill_width_p / 8);
  localparam int cnt_w_lp  = safe_clog2(block_size_in_fills_p + 1);
  localparam logic [cnt_w_lp-1:0] block_lp = cnt_w_lp'(block_size_in_fills_p);
  localparam logic [cnt_w_lp-1:0] last_lp  = cnt_w_lp'(block_size_in_fills_p - 1);

  typedef enum logic [1:0] {e_ready, e_read, e_write} state_e;

  state_e state_r, state_n;

  bsg_cache_dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  logic [lg_els_lp-1:0] base_r;
  logic [cnt_w_lp-1:0]  cnt_r;    // beats issued (read) or written (write)
  logic [cnt_w_lp-1:0]  done_r;   // read beats consumed by the cache
  logic                 out_v_r;  // RAM output latch holds an unconsumed beat
  logic                 consume;
  logic                 rd_issue;
  logic                 wr_en;
  logic [lg_els_lp-1:0] mem_addr;

  assign consume = out_v_r & dma_data_ready_and_i;

  // Next state and handshakes. Outputs are gated with reset so nothing is
  // acknowledged while reset is held.
  always_comb begin
    state_n         = state_r;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_yumi_o = 1'b0;
    rd_issue        = 1'b0;
    wr_en           = 1'b0;
    case (state_r)
      e_ready: begin
        dma_pkt_yumi_o = dma_pkt_v_i;
        if (dma_pkt_v_i) state_n = pkt.write_not_read ? e_write : e_read;
      end
      e_read: begin
        // The RAM output latch is the 1-entry output register: a new read
        // may only overwrite it when it is empty or drained this cycle.
        rd_issue = (cnt_r != block_lp) & (~out_v_r | consume);
        if (consume && done_r == last_lp) state_n = e_ready;
      end
      e_write: begin
        dma_data_yumi_o = dma_data_v_i;
        wr_en           = dma_data_v_i;
        if (dma_data_v_i && cnt_r == last_lp) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
    if (reset_i) begin
      dma_pkt_yumi_o  = 1'b0;
      dma_data_yumi_o = 1'b0;
      rd_issue        = 1'b0;
      wr_en           = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      base_r  <= '0;
      cnt_r   <= '0;
      done_r  <= '0;
      out_v_r <= 1'b0;
    end else begin
      if (dma_pkt_yumi_o) begin
        // Sub-beat address bits drop out in the shift; the cast keeps the
        // beat index modulo the (power-of-two) depth.
        base_r <= lg_els_lp'(pkt.addr >> offset_lp);
        cnt_r  <= '0;
        done_r <= '0;
      end else begin
        if (rd_issue | wr_en) cnt_r  <= cnt_r + 1'b1;
        if (consume)          done_r <= done_r + 1'b1;
      end
      out_v_r <= rd_issue | (out_v_r & ~consume);
    end
  end

  assign mem_addr     = base_r + lg_els_lp'(cnt_r);
  assign dma_data_v_o = out_v_r;

  bsg_mem_1rw_sync #(
    .width_p (fill_width_p),
    .els_p   (mem_els_p)
  ) mem (
    .clk_i  (clk_i),
    .v_i    (rd_issue | wr_en),
    .w_i    (wr_en),
    .addr_i (mem_addr),
    .data_i (dma_data_i),
    .data_o (dma_data_o)
  );

endmodule

// File: tb/tb_bp_dma_responder.sv
module tb_bp_dma_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [28:0] pkt;
  logic        pkt_v, pkt_yumi;
  logic [63:0] rd_data;
  logic        rd_v, ready;
  logic [63:0] wr_data;
  logic        wr_v, wr_yumi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_dma_responder dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .dma_pkt_i            (pkt),
    .dma_pkt_v_i          (pkt_v),
    .dma_pkt_yumi_o       (pkt_yumi),
    .dma_data_o           (rd_data),
    .dma_data_v_o         (rd_v),
    .dma_data_ready_and_i (ready),
    .dma_data_i           (wr_data),
    .dma_data_v_i         (wr_v),
    .dma_data_yumi_o      (wr_yumi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 8-beat write of first+k, no gaps
  task automatic wr_burst(input logic [27:0] addr, input logic [63:0] first, input string tag);
    @(negedge clk); pkt = {1'b1, addr}; pkt_v = 1'b1; wr_v = 1'b0; #1;
    chk({tag, "_yumi"}, pkt_yumi, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); pkt_v = 1'b0; wr_v = 1'b1; wr_data = first + 64'(k); #1;
      chk({tag, "_dyumi"}, wr_yumi, 1);
    end
    @(negedge clk); wr_v = 1'b0;
  endtask

  // 8-beat read with ready held high; checks latency, order and the first
  // ncheck beats against first+k
  task automatic rd_burst(input logic [27:0] addr, input logic [63:0] first, input int ncheck,
                          input string tag);
    @(negedge clk); pkt = {1'b0, addr}; pkt_v = 1'b1; ready = 1'b1; wr_v = 1'b0; #1;
    chk({tag, "_yumi"}, pkt_yumi, 1);
    @(negedge clk); pkt_v = 1'b0; #1;
    chk({tag, "_lat1"}, rd_v, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk({tag, "_v"}, rd_v, 1);
      if (k < ncheck) chk({tag, "_data"}, rd_data, first + 64'(k));
    end
    @(negedge clk); #1;
    chk({tag, "_end"}, rd_v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, nyumi, consec;
    logic prev_v, prev_rdy, prev_yumi, found;
    logic [63:0] prev_d;
    logic [3:0] pat;

    // reset: handshakes blocked even with inputs valid
    reset = 1'b1; pkt = '0; pkt_v = 1'b1; wr_v = 1'b1; wr_data = '0; ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_pkt_yumi", pkt_yumi, 0);
    chk("rst_rd_v", rd_v, 0);
    chk("rst_wr_yumi", wr_yumi, 0);
    @(negedge clk); reset = 1'b0; pkt_v = 1'b0; wr_v = 1'b0; #1;
    chk("idle_rd_v", rd_v, 0);

    // write 0x40 with 1..8, read back
    wr_burst(28'h40, 64'h1, "wr40");
    rd_burst(28'h40, 64'h1, 8, "rd40");

    // gapped write at 0x100: valid 1,0,1,0,...; gap beats carry junk
    @(negedge clk); pkt = {1'b1, 28'h100}; pkt_v = 1'b1; #1;
    chk("gap_yumi", pkt_yumi, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); pkt_v = 1'b0; wr_v = 1'b1; wr_data = 64'hA0 + 64'(k); #1;
      chk("gap_dyumi", wr_yumi, 1);
      if (k < 7) begin
        @(negedge clk); wr_v = 1'b0; wr_data = 64'hDEAD; #1;
        chk("gap_nodyumi", wr_yumi, 0);
      end
    end
    @(negedge clk); wr_v = 1'b0;

    // read back 0x100 with ready toggling 1,0,0,1
    pkt = {1'b0, 28'h100}; pkt_v = 1'b1; ready = 1'b1; #1;
    chk("tog_yumi", pkt_yumi, 1);
    @(negedge clk); pkt_v = 1'b0;
    pat = 4'b1001;  // pat[0] first
    idx = 0; cyc = 0; prev_v = 1'b0; prev_rdy = 1'b1; prev_d = '0;
    while (idx < 8 && cyc < 40) begin
      @(negedge clk); ready = pat[cyc % 4]; #1;
      if (rd_v) begin
        chk("tog_data", rd_data, 64'hA0 + 64'(idx));
        if (prev_v && !prev_rdy) chk("tog_stable", rd_data, prev_d);
        if (ready) idx++;
      end
      prev_v = rd_v; prev_rdy = ready; prev_d = rd_data;
      cyc++;
    end
    chk("tog_count", 64'(idx), 64'd8);
    @(negedge clk); ready = 1'b1; #1;
    chk("tog_end", rd_v, 0);

    // wrap: beat 1020 -> beats 4..7 land at 0..3
    wr_burst(28'h1FE0, 64'h100, "wrap_wr");
    rd_burst(28'h0, 64'h104, 4, "wrap_lo");
    rd_burst(28'h1FE0, 64'h100, 8, "wrap_rd");

    // pkt_v held high: one accept per 10-cycle transfer, never back to back
    @(negedge clk); pkt = {1'b0, 28'h40}; pkt_v = 1'b1; ready = 1'b1;
    nyumi = 0; consec = 0; prev_yumi = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (pkt_yumi) begin
        nyumi++;
        if (prev_yumi) consec++;
      end
      prev_yumi = pkt_yumi;
    end
    chk("hold_nyumi", 64'(nyumi), 64'd3);
    chk("hold_consec", 64'(consec), 64'd0);

    // reset mid-read at beat 3, addr 0x45 (low bits ignored -> beat 8)
    @(negedge clk); pkt_v = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (pkt_yumi == 1'b0 && rd_v == 1'b0 && c > 2) found = 1'b1;
    end
    chk("drain_idle", 64'(found), 64'd1);
    pkt = {1'b0, 28'h45}; pkt_v = 1'b1; #1;
    chk("lowbits_yumi", pkt_yumi, 1);
    @(negedge clk); pkt_v = 1'b0;
    @(negedge clk); #1;
    chk("lowbits_first", rd_data, 64'h1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (rd_v && rd_data == 64'h4) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("beat3_seen", 64'(found), 64'd1);
    reset = 1'b1; pkt_v = 1'b1; wr_v = 1'b1; #1;
    chk("midrst_rd_v", rd_v, 0);
    chk("midrst_pkt_yumi", pkt_yumi, 0);
    chk("midrst_wr_yumi", wr_yumi, 0);
    @(negedge clk); reset = 1'b0; pkt = {1'b0, 28'h40}; pkt_v = 1'b1; wr_v = 1'b0; #1;
    chk("postrst_yumi", pkt_yumi, 1);
    @(negedge clk); pkt_v = 1'b0; #1;
    chk("postrst_lat", rd_v, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("postrst_data", rd_data, 64'h1 + 64'(k));
    end
    @(negedge clk); #1;
    chk("postrst_end", rd_v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
